// File: rtl/matrix_mac_pkg.sv
// Shared types and helpers for the matrix MAC sequencer.
// Holds the sequencer state encoding and the flat element addressing rule.
package matrix_mac_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    SETTLE = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } seq_state_t;

  // Operand SRAM read latency; the MAC enable trails the read strobe by this much.
  localparam int MAC_RD_LATENCY = 1;

  function automatic int unsigned flat_addr(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned dim);
    return row * dim + col;
  endfunction

endpackage

// File: rtl/matrix_idx_counter.sv
// Nested row/column/inner-product index counter for the MAC sequencer.
// k walks the inner product; next_elem steps j, then i, in row-major order.
module matrix_idx_counter #(
  parameter int DIM   = 4,
  parameter int IDX_W = $clog2(DIM)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_all,
  input  logic             inc_k,
  input  logic             next_elem,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             k_last,
  output logic             j_last,
  output logic             i_last
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  assign k_last = (k == IDX_MAX);
  assign j_last = (j == IDX_MAX);
  assign i_last = (i == IDX_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr_all) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (inc_k) begin
        k <= k_last ? '0 : k + IDX_ONE;
      end
      if (next_elem) begin
        if (j_last) begin
          j <= '0;
          i <= i_last ? '0 : i + IDX_ONE;
        end else begin
          j <= j + IDX_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Sequences the MAC unit through C = A x B, one C element at a time, and
// hands each finished accumulator value to the result buffer over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | mac_clear pulse, k reset
// RUN    | DIM operand reads, k = 0..DIM-1
// DRAIN  | last delayed mac_enable accumulates
// SETTLE | capture mac_result and C address
// WRITE  | res_valid held until res_ready
// DONE   | one-cycle done pulse
module matrix_mac_sequencer
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  parameter int IDX_W      = $clog2(DIM),
  parameter int ADDR_W     = 2 * IDX_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     a_addr,
  output logic [ADDR_W-1:0]     b_addr,
  output logic                  mac_enable,
  output logic                  mac_clear,
  input  logic [DATA_WIDTH-1:0] mac_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ADDR_W-1:0]     res_addr,
  output logic [DATA_WIDTH-1:0] res_data
);

  seq_state_t state;

  logic [IDX_W-1:0]          i;
  logic [IDX_W-1:0]          j;
  logic [IDX_W-1:0]          k;
  logic                      k_last;
  logic                      j_last;
  logic                      i_last;
  logic                      clr_all;
  logic                      inc_k;
  logic                      next_elem;
  logic [MAC_RD_LATENCY-1:0] rd_pipe;

  matrix_idx_counter #(
    .DIM   (DIM),
    .IDX_W (IDX_W)
  ) u_idx (
    .clock     (clock),
    .reset     (reset),
    .clr_all   (clr_all),
    .inc_k     (inc_k),
    .next_elem (next_elem),
    .i         (i),
    .j         (j),
    .k         (k),
    .k_last    (k_last),
    .j_last    (j_last),
    .i_last    (i_last)
  );

  // Addresses come straight off the index flops, so they are glitch-free.
  assign a_addr     = ADDR_W'(flat_addr(32'(i), 32'(k), DIM));
  assign b_addr     = ADDR_W'(flat_addr(32'(k), 32'(j), DIM));
  assign mac_enable = rd_pipe[MAC_RD_LATENCY-1];

  // Indices sit at zero whenever no element is in progress.
  always_comb begin
    clr_all   = 1'b0;
    inc_k     = 1'b0;
    next_elem = 1'b0;
    if (abort || state == IDLE || state == DONE) begin
      clr_all = 1'b1;
    end else begin
      inc_k     = (state == RUN);
      next_elem = (state == WRITE) && res_ready && !(i_last && j_last);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_pipe   <= '0;
      mac_clear <= 1'b0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
    end else begin
      done      <= 1'b0;
      mac_clear <= 1'b0;
      rd_pipe   <= MAC_RD_LATENCY'({rd_pipe, rd_en});
      if (abort && state != IDLE) begin
        // Squash the in-flight accumulate and leave the MAC cleared.
        state     <= IDLE;
        busy      <= 1'b0;
        rd_en     <= 1'b0;
        rd_pipe   <= '0;
        res_valid <= 1'b0;
        mac_clear <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              state     <= CLEAR;
              busy      <= 1'b1;
              mac_clear <= 1'b1;
            end
          end
          CLEAR: begin
            state <= RUN;
            rd_en <= 1'b1;
          end
          RUN: begin
            if (k_last) begin
              state <= DRAIN;
              rd_en <= 1'b0;
            end
          end
          DRAIN: begin
            state <= SETTLE;
          end
          SETTLE: begin
            state     <= WRITE;
            res_data  <= mac_result;
            res_addr  <= ADDR_W'(flat_addr(32'(i), 32'(j), DIM));
            res_valid <= 1'b1;
          end
          WRITE: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (i_last && j_last) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state     <= CLEAR;
                mac_clear <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            res_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Self-checking bench for matrix_mac_sequencer at DIM=4 with a behavioural
// operand SRAM (1-cycle read) and MAC accumulator around it.
module tb_matrix_mac_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [3:0] a_addr;
  logic [3:0] b_addr;
  logic       mac_enable;
  logic       mac_clear;
  logic [7:0] mac_result;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_addr;
  logic [7:0] res_data;

  matrix_mac_sequencer #(
    .DATA_WIDTH (8),
    .DIM        (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .a_addr     (a_addr),
    .b_addr     (b_addr),
    .mac_enable (mac_enable),
    .mac_clear  (mac_clear),
    .mac_result (mac_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_addr   (res_addr),
    .res_data   (res_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment: operand buffers and MAC accumulator.
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  logic [7:0] a_q = '0;
  logic [7:0] b_q = '0;
  logic [7:0] acc = '0;

  always @(posedge clock) begin
    if (rd_en) begin
      a_q <= mem_a[a_addr];
      b_q <= mem_b[b_addr];
    end
    if (mac_clear) acc <= '0;
    else if (mac_enable) acc <= acc + 8'(a_q * b_q);
  end
  assign mac_result = acc;

  logic [25:0] outs;
  assign outs = {busy, done, rd_en, a_addr, b_addr, mac_enable, mac_clear,
                 res_valid, res_addr, res_data};

  typedef struct {
    logic [3:0] addr;
    logic [7:0] d_ident;
    logic [7:0] d_const;
  } wr_vec_t;
  wr_vec_t tbl [16];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int wr_addr_q [$];
  int wr_data_q [$];
  int rd_a_q [$];
  int rd_b_q [$];
  int done_cnt, done_cyc, done_busy, busy_after, overlap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_ident();
    for (int e = 0; e < 16; e++) begin
      mem_a[e] = (e / 4 == e % 4) ? 8'd1 : 8'd0;
      mem_b[e] = 8'(e);
    end
  endtask

  task automatic load_const();
    for (int e = 0; e < 16; e++) begin
      mem_a[e] = 8'd2;
      mem_b[e] = 8'd3;
    end
  endtask

  // Pulses start and follows one job; cyc=1 is the first cycle after the start edge.
  task automatic run_job(input int stall_addr, input int stall_n, input int stall_data,
                         input int abort_a, input int abort_b, input int reset_addr,
                         input bit repulse);
    int stall_left, tail, quiet_bad;
    bit finished, hit, stall_active;
    wr_addr_q.delete(); wr_data_q.delete(); rd_a_q.delete(); rd_b_q.delete();
    done_cnt = 0; done_cyc = -1; done_busy = -1; busy_after = -1; overlap = 0;
    stall_left = stall_n; stall_active = 0; tail = -1; finished = 0;
    res_ready = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 400) begin
      hit = 0;
      if (mac_enable && mac_clear) overlap++;
      if (cyc == tail) begin
        busy_after = int'(busy);
        finished = 1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          done_busy = int'(busy);
          tail = cyc + 1;
        end
      end
      if (rd_en) begin
        rd_a_q.push_back(int'(a_addr));
        rd_b_q.push_back(int'(b_addr));
      end
      if (repulse) start = (cyc == 50);
      if (reset_addr >= 0 && res_valid && int'(res_addr) == reset_addr) begin
        #1 reset = 1'b0;
        #1 chk("reset_mid_write_outputs", 32'(outs), 32'd0);
        chk("reset_mid_write_busy", busy, 1'b0);
        #1 reset = 1'b1;
        finished = 1;
        hit = 1;
      end else if (abort_a >= 0 && rd_en && int'(a_addr) == abort_a && int'(b_addr) == abort_b) begin
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_mac_clear", mac_clear, 1'b1);
        chk("abort_rd_en", rd_en, 1'b0);
        chk("abort_mac_enable", mac_enable, 1'b0);
        chk("abort_res_valid", res_valid, 1'b0);
        quiet_bad = 0;
        repeat (20) begin
          @(posedge clock); #1;
          if (rd_en || res_valid || done) quiet_bad++;
        end
        chk("abort_quiet", quiet_bad, 0);
        finished = 1;
        hit = 1;
      end
      if (!hit) begin
        if (stall_left > 0 && (stall_active || (res_valid && int'(res_addr) == stall_addr))) begin
          stall_active = 1;
          res_ready = 1'b0;
          chk($sformatf("stall_valid_%0d", stall_left), res_valid, 1'b1);
          chk($sformatf("stall_addr_%0d", stall_left), res_addr, stall_addr);
          chk($sformatf("stall_data_%0d", stall_left), res_data, stall_data);
          stall_left--;
        end else begin
          res_ready = 1'b1;
        end
        if (res_valid && res_ready) begin
          wr_addr_q.push_back(int'(res_addr));
          wr_data_q.push_back(int'(res_data));
        end
      end
      if (!finished) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    res_ready = 1'b1;
    start = 1'b0;
    chk("job_finished_in_budget", finished, 1'b1);
  endtask

  task automatic check_writes(input bit ident, input string tag);
    chk({tag, "_wr_count"}, wr_addr_q.size(), 16);
    for (int e = 0; e < 16 && e < wr_addr_q.size(); e++) begin
      chk($sformatf("%s_addr[%0d]", tag, e), wr_addr_q[e], tbl[e].addr);
      chk($sformatf("%s_data[%0d]", tag, e), wr_data_q[e],
          ident ? tbl[e].d_ident : tbl[e].d_const);
    end
  endtask

  initial begin
    // Identity A makes C equal B, and B[r][c]=r*4+c equals the flat address.
    // All-2 times all-3 over four terms gives 24 everywhere.
    for (int e = 0; e < 16; e++) begin
      tbl[e].addr    = 4'(e);
      tbl[e].d_ident = 8'(e);
      tbl[e].d_const = 8'd24;
    end
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;
    load_ident();

    #3;
    chk("reset_outputs", 32'(outs), 32'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    chk("idle_outputs", 32'(outs), 32'd0);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", busy, 1'b0);
    chk("start_abort_idle_clear", mac_clear, 1'b0);
    repeat (2) @(posedge clock);
    #1 chk("start_abort_idle_later", busy, 1'b0);

    // Identity job with a stray start pulse while busy.
    run_job(-1, 0, 0, -1, -1, -1, 1'b1);
    check_writes(1'b1, "ident");
    chk("ident_done_cycle", done_cyc, 129);
    chk("ident_done_count", done_cnt, 1);
    chk("ident_busy_at_done", done_busy, 1);
    chk("ident_busy_after", busy_after, 0);
    chk("ident_no_overlap", overlap, 0);

    load_const();
    run_job(-1, 0, 0, -1, -1, -1, 1'b0);
    check_writes(1'b0, "const");
    chk("const_done_cycle", done_cyc, 129);
    chk("const_rd_count", rd_a_q.size(), 64);
    if (rd_a_q.size() >= 28) begin
      for (int t = 0; t < 4; t++) begin
        chk($sformatf("elem12_a_addr_k%0d", t), rd_a_q[24 + t], 4 + t);
        chk($sformatf("elem12_b_addr_k%0d", t), rd_b_q[24 + t], 2 + 4 * t);
      end
    end

    load_ident();
    run_job(3, 5, 3, -1, -1, -1, 1'b0);
    check_writes(1'b1, "stall");
    chk("stall_done_cycle", done_cyc, 134);
    chk("stall_done_count", done_cnt, 1);

    // Abort at element 5 (i=1,j=1) while k=2: a_addr=6, b_addr=9.
    run_job(-1, 0, 0, 6, 9, -1, 1'b0);
    chk("abort_writes_before", wr_addr_q.size(), 5);
    chk("abort_no_done", done_cnt, 0);
    run_job(-1, 0, 0, -1, -1, -1, 1'b0);
    check_writes(1'b1, "post_abort");
    chk("post_abort_done_cycle", done_cyc, 129);

    run_job(-1, 0, 0, -1, -1, 2, 1'b0);
    chk("reset_writes_before", wr_addr_q.size(), 2);
    chk("reset_no_done", done_cnt, 0);
    run_job(-1, 0, 0, -1, -1, -1, 1'b0);
    check_writes(1'b1, "post_reset");
    chk("post_reset_done_cycle", done_cyc, 129);
    chk("post_reset_done_count", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_mac_sequencer.md
Name: matrix_mac_sequencer

Overview:
Controller that sequences the matrix MAC unit through a full DIM x DIM matrix multiply, C = A x B.
- Generates operand read addresses for the A and B buffers.
- Drives the MAC unit's enable and clear inputs.
- Captures each finished accumulator value and presents it on a valid/ready result write port.
- Sits between the operand SRAMs, the MAC unit and the result buffer; software/top-level control uses start/busy/done/abort.

Parameters:
DATA_WIDTH, 8, width of the MAC result captured and forwarded
DIM, 4, matrix dimension; power of two, 2..16
IDX_W, $clog2(DIM), width of row/column/k index
ADDR_W, 2*IDX_W, width of flat element address (row*DIM+col)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a multiply; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last result is accepted
rd_en  out  1  operand read strobe to A and B buffers
a_addr  out  ADDR_W  A element address, i*DIM+k
b_addr  out  ADDR_W  B element address, k*DIM+j
mac_enable  out  1  MAC accumulate enable
mac_clear  out  1  MAC accumulator clear
mac_result  in  DATA_WIDTH  MAC accumulator output
res_valid  out  1  result write valid
res_ready  in  1  result buffer ready
res_addr  out  ADDR_W  C element address, i*DIM+j
res_data  out  DATA_WIDTH  registered copy of mac_result

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; i,j,k=0; all outputs 0.
- Operand buffers have 1-cycle read latency: mac_enable is rd_en delayed by one register.
- MAC accumulator updates on an edge with mac_enable=1; mac_result is valid the following cycle.
- States: IDLE, CLEAR, RUN, DRAIN, SETTLE, WRITE, DONE.
- IDLE: start=1 -> CLEAR with i=j=0. start during any other state is ignored.
- CLEAR (1 cycle): mac_clear=1; k=0 -> RUN.
- RUN (DIM cycles): rd_en=1, a_addr=i*DIM+k, b_addr=k*DIM+j, k increments. After k=DIM-1 -> DRAIN.
- DRAIN (1 cycle): delayed mac_enable covers the last operand; rd_en=0 -> SETTLE.
- SETTLE (1 cycle): res_data <= mac_result, res_addr <= i*DIM+j -> WRITE.
- WRITE: res_valid=1. res_data and res_addr are held stable until res_ready=1; that handshake completes in the same cycle.
  - On handshake: if j<DIM-1, j++ and -> CLEAR.
  - Else if i<DIM-1, j=0, i++ and -> CLEAR.
  - Else -> DONE.
- DONE (1 cycle): done=1, busy=1 -> IDLE.
- Timing with res_ready held 1:
  - Each element takes DIM+4 cycles.
  - The total from the start edge to the done pulse is DIM*DIM*(DIM+4)+1 cycles; DIM=4 gives 129.
- Index counters wrap only via the explicit resets above; no address exceeds DIM*DIM-1.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; rd_en, mac_enable and res_valid are forced 0 on the next edge.
  - The in-flight delayed mac_enable is squashed; mac_clear pulses 1 for that cycle.
  - No done pulse.
- abort and start together in IDLE: abort wins, so the state stays IDLE.
- A handshake in the same cycle as abort is lost; the result buffer must treat that beat as accepted.
- mac_enable and mac_clear are never high in the same cycle.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.

Decomposition:
- Package matrix_mac_pkg:
  - State enum seq_state_t.
  - Constant MAC_RD_LATENCY=1.
  - Function flat_addr(row,col,DIM).
- Single sub-module matrix_idx_counter: nested i/j/k counter with wrap flags (k_last, j_last, i_last). It is instantiated once; the FSM stays in the top.

Test Plan:
- DIM=4, identity A, B[r][c]=r*4+c, res_ready=1, pulse start:
  - 16 writes in order res_addr 0..15 with res_data=B.
  - done exactly 129 cycles after the start edge; busy low one cycle later.
- DIM=4, A all 2, B all 3: every res_data=24.
  - rd_en addresses for element (1,2): a_addr 4,5,6,7 and b_addr 2,6,10,14.
- Backpressure: res_ready low for 5 cycles at element 3:
  - res_valid, res_addr=3 and res_data held constant.
  - Total length grows by exactly 5 cycles.
- Abort during RUN of element 5 (k=2):
  - IDLE next cycle; mac_clear pulse; no further rd_en or res_valid; no done.
  - A new start then produces all 16 correct results.
- start re-pulsed while busy and start+abort in IDLE:
  - Both ignored.
  - The running job completes unchanged with a single done.
- reset deasserted-asserted-deasserted mid-WRITE:
  - All outputs 0 asynchronously; IDLE; busy=0.
  - The next start runs normally from element 0.
